// File: rtl/multi_fifo_arbiter.sv
// Round-robin arbiter draining N_CH first-word-fall-through FIFOs into one registered output stream.
// Supports packet hold, an optional burst limit and downstream backpressure.
module multi_fifo_arbiter #(
    parameter int N_CH       = 7,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int CH_BITS   = $clog2(N_CH)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [N_CH-1:0]              CH_ENABLE,
    input  logic [N_CH-1:0]              WRITE_REQ,
    input  logic [N_CH-1:0]              HOLD_REQ,
    input  logic [N_CH*DATA_WIDTH-1:0]   DATA_IN,
    output logic [N_CH-1:0]              READ_GRANT,
    input  logic                         READY_OUT,
    output logic                         WRITE_OUT,
    output logic [DATA_WIDTH-1:0]        DATA_OUT,
    output logic [CH_BITS-1:0]           CURRENT_CH
);

    localparam int BC_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);

    typedef enum logic {IDLE, SERVE} state_t;

    // Saturating count; with MAX_BURST=0 the limit is 0, so the counter never moves.
    function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v);
        return (v >= BURST_MAX) ? v : v + 1'b1;
    endfunction

    state_t                  state_q, state_d;
    logic [CH_BITS-1:0]      ptr_q, ptr_d;
    logic [CH_BITS-1:0]      cur_q, cur_d;
    logic [BC_W-1:0]         burst_cnt_q, burst_cnt_d;
    logic                    write_out_q, write_out_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic [CH_BITS-1:0]      current_ch_q, current_ch_d;

    logic [N_CH-1:0]         eligible;
    logic [N_CH-1:0]         read_grant;
    logic [CH_BITS-1:0]      cand;
    logic [CH_BITS-1:0]      sel_idx;
    logic                    sel_found;
    logic                    cur_grant;
    logic [BC_W-1:0]         cnt_inc;
    logic                    limit_hit;
    logic                    leave;

    always_comb begin
        eligible     = WRITE_REQ & CH_ENABLE;
        read_grant   = '0;
        cand         = '0;
        sel_idx      = '0;
        sel_found    = 1'b0;
        cur_grant    = 1'b0;
        cnt_inc      = sat_inc(burst_cnt_q);
        limit_hit    = 1'b0;
        leave        = 1'b0;
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_d        = cur_q;
        burst_cnt_d  = burst_cnt_q;
        write_out_d  = 1'b0;
        data_out_d   = data_out_q;
        current_ch_d = current_ch_q;

        // Search starts just after the last served channel so service rotates fairly.
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_BITS'((int'(ptr_q) + i) % N_CH);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end

        if (state_q == SERVE) begin
            cur_grant           = READY_OUT & WRITE_REQ[cur_q] & CH_ENABLE[cur_q];
            read_grant[cur_q]   = cur_grant;
            limit_hit = (MAX_BURST != 0) && cur_grant && (cnt_inc == BURST_MAX);
            leave     = !CH_ENABLE[cur_q]
                      || (!WRITE_REQ[cur_q] && !HOLD_REQ[cur_q])
                      || (limit_hit && !HOLD_REQ[cur_q]);
            if (READY_OUT) begin
                if (cur_grant) begin
                    burst_cnt_d = cnt_inc;
                end
                if (leave) begin
                    state_d = IDLE;
                    ptr_d   = cur_q;
                end
            end
        end else if (sel_found) begin
            state_d     = SERVE;
            cur_d       = sel_idx;
            burst_cnt_d = '0;
        end

        if (cur_grant) begin
            write_out_d  = 1'b1;
            data_out_d   = DATA_IN[cur_q*DATA_WIDTH +: DATA_WIDTH];
            current_ch_d = cur_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            ptr_q        <= CH_BITS'(N_CH - 1);
            cur_q        <= '0;
            burst_cnt_q  <= '0;
            write_out_q  <= 1'b0;
            data_out_q   <= '0;
            current_ch_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_q        <= cur_d;
            burst_cnt_q  <= burst_cnt_d;
            write_out_q  <= write_out_d;
            data_out_q   <= data_out_d;
            current_ch_q <= current_ch_d;
        end
    end

    assign READ_GRANT = read_grant;
    assign WRITE_OUT  = write_out_q;
    assign DATA_OUT   = data_out_q;
    assign CURRENT_CH = current_ch_q;

endmodule

// File: tb/tb_multi_fifo_arbiter.sv
// Directed bench for multi_fifo_arbiter: FWFT FIFO sources, a rule-level arbitration model
// checked every cycle, and literal expected output orders per scenario.
module tb_multi_fifo_arbiter;
    localparam int N  = 7;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    en, wreq, hold, grant;
    logic [N*DW-1:0] din;
    logic            ready, wout;
    logic [DW-1:0]   dout;
    logic [2:0]      cch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_fifo_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLK(clk), .RST_N(rst_n), .CH_ENABLE(en), .WRITE_REQ(wreq), .HOLD_REQ(hold),
        .DATA_IN(din), .READ_GRANT(grant), .READY_OUT(ready), .WRITE_OUT(wout),
        .DATA_OUT(dout), .CURRENT_CH(cch)
    );

    // Source FIFOs
    logic [31:0] mem [N][DEPTH];
    int          head [N];
    int          tail [N];
    logic [N-1:0] gate;
    logic [N-1:0] g_smp;
    logic [31:0] log_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] v);
        mem[ch][tail[ch]] = v;
        tail[ch]++;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            wreq[k] = (head[k] < tail[k]) && !gate[k];
            din[k*DW +: DW] = (head[k] < tail[k]) ? mem[k][head[k]] : 32'h0;
        end
    endtask

    task automatic cyc(input int n);
        drive();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            for (int k = 0; k < N; k++)
                if (g_smp[k] && head[k] < tail[k]) head[k]++;
            #1;
            drive();
        end
    endtask

    task automatic check_log(input string name, input logic [31:0] exp_q[$]);
        chk({name, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(name, (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        log_q.delete();
    endtask

    // Rule-level model: serving channel, rotation pointer, words taken in this burst.
    logic        m_serve;
    int          m_cur, m_ptr, m_cnt, m_ch;
    logic        m_wo;
    logic [31:0] m_dout;

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_serve && ready && wreq[m_cur] && en[m_cur]) g[m_cur] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] g;
        int  nc, cnt_next;
        bit  found, leave;
        if (!rst_n) begin
            m_serve <= 1'b0; m_cur <= 0; m_ptr <= N - 1; m_cnt <= 0;
            m_wo <= 1'b0; m_dout <= '0; m_ch <= 0;
        end else begin
            g = exp_grant();
            m_wo <= (g != 0);
            if (g != 0) begin
                m_dout <= din[m_cur*DW +: DW];
                m_ch   <= m_cur;
            end
            if (!m_serve) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    nc = (m_ptr + k) % N;
                    if (!found && wreq[nc] && en[nc]) begin
                        found = 1;
                        m_cur <= nc; m_cnt <= 0; m_serve <= 1'b1;
                    end
                end
            end else if (ready) begin
                cnt_next = (g != 0) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : m_cnt;
                m_cnt <= cnt_next;
                leave = !en[m_cur] || (!wreq[m_cur] && !hold[m_cur])
                     || ((g != 0) && cnt_next == MB && !hold[m_cur]);
                if (leave) begin
                    m_serve <= 1'b0;
                    m_ptr   <= m_cur;
                end
            end
        end
    end

    always @(negedge clk) begin
        g_smp <= grant;
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
        chk("write_out", 32'(wout), 32'(m_wo));
        chk("data_out", dout, m_dout);
        chk("current_ch", 32'(cch), 32'(m_ch));
        if (wout) log_q.push_back(dout);
    end

    logic [31:0] e [$];

    initial begin
        rst_n = 1'b0; en = '1; hold = '0; gate = '0; ready = 1'b1; g_smp = '0;
        for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wout", 32'(wout), 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_cch", 32'(cch), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // Round robin over ch0, ch3, ch6
        push(0, 32'h1000); push(0, 32'h1001);
        push(3, 32'h1300); push(3, 32'h1301);
        push(6, 32'h1600); push(6, 32'h1601);
        cyc(1);
        #1 chk("lat_grant", 32'(grant), 32'h01);
        cyc(1);
        #1 chk("lat_wout", 32'(wout), 32'h1);
        chk("lat_dout", dout, 32'h1000);
        cyc(20);
        e = '{32'h1000, 32'h1001, 32'h1300, 32'h1301, 32'h1600, 32'h1601};
        check_log("rr_order", e);

        // Burst limit 4 with a competing single-word channel
        for (int i = 0; i < 10; i++) push(1, 32'h2100 + i);
        push(2, 32'h2200);
        cyc(40);
        e = '{32'h2100, 32'h2101, 32'h2102, 32'h2103, 32'h2200,
              32'h2104, 32'h2105, 32'h2106, 32'h2107, 32'h2108, 32'h2109};
        check_log("burst_order", e);

        // Hold keeps ch2 granted while its request toggles
        push(2, 32'h3200); push(2, 32'h3201); push(5, 32'h3500);
        hold[2] = 1'b1;
        cyc(2);
        gate[2] = 1'b1;
        cyc(2);
        #1 chk("hold_gap_grant", 32'(grant), 32'h0);
        gate[2] = 1'b0;
        cyc(1);
        cyc(3);
        #1 chk("hold_no_ch5", 32'(grant), 32'h0);
        hold[2] = 1'b0;
        cyc(8);
        e = '{32'h3200, 32'h3201, 32'h3500};
        check_log("hold_order", e);

        // Backpressure for three cycles mid-burst
        for (int i = 0; i < 6; i++) push(0, 32'h4000 + i);
        cyc(3);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_grant", 32'(grant), 32'h0);
            cyc(1);
        end
        ready = 1'b1;
        cyc(20);
        e = '{32'h4000, 32'h4001, 32'h4002, 32'h4003, 32'h4004, 32'h4005};
        check_log("stall_order", e);

        // Disable overrides hold
        for (int i = 0; i < 6; i++) push(4, 32'h5400 + i);
        hold[4] = 1'b1;
        cyc(3);
        push(1, 32'h5100);
        en[4] = 1'b0;
        drive();
        #1 chk("disable_grant", 32'(grant), 32'h0);
        cyc(6);
        en[4] = 1'b1; hold[4] = 1'b0;
        cyc(20);
        e = '{32'h5400, 32'h5401, 32'h5100, 32'h5402, 32'h5403, 32'h5404, 32'h5405};
        check_log("disable_order", e);

        // Reset mid-burst, then ch0 gets first priority
        for (int i = 0; i < 6; i++) push(3, 32'h6300 + i);
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_wout", 32'(wout), 32'h0);
        chk("mid_rst_dout", dout, 32'h0);
        chk("mid_rst_cch", 32'(cch), 32'h0);
        push(0, 32'h6000); push(5, 32'h6500);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        #1 chk("post_rst_grant", 32'(grant), 32'h01);
        cyc(20);
        e = '{32'h6300, 32'h6000, 32'h6302, 32'h6303, 32'h6304, 32'h6305, 32'h6500};
        check_log("reset_order", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
